// File: rtl/dma_axi_wr_engine_pkg.sv
// Shared types and AXI constants for the DMA write-side drain engine.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    AW,
    W,
    B,
    DONE
  } wr_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned AXI_4K_BYTES  = 4096;

  // AXI AxSIZE encoding for a full-width beat of the given data width.
  function automatic logic [2:0] axi_size_for(input int unsigned dwidth);
    return 3'($clog2(dwidth / 8));
  endfunction

endpackage

// File: rtl/dma_axi_wr_engine_if.sv
// AXI4 write-channel bundle (AW, W, B) between the DMA write engine and memory.
interface dma_axi_wr_engine_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);

  logic [AWIDTH-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DWIDTH-1:0]   wdata;
  logic [DWIDTH/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/dma_axi_wr_engine_burst_calc.sv
// Combinational burst sizing: smallest of words left, MAX_BURST and the
// words remaining before the next 4 KB boundary.
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int LWIDTH    = 16,
  parameter int DWIDTH    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic [11:0]       addr_offset,
  input  logic [LWIDTH-1:0] remaining,
  output logic [8:0]        beats,
  output logic [7:0]        awlen
);

  localparam int unsigned BYTE_SHIFT = $clog2(DWIDTH / 8);

  logic [31:0] to_boundary;
  logic [31:0] limit;

  // An aligned address always leaves at least one word before the boundary.
  always_comb begin
    to_boundary = (32'(AXI_4K_BYTES) - {20'd0, addr_offset}) >> BYTE_SHIFT;
    limit       = 32'(MAX_BURST);
    if (to_boundary < limit) limit = to_boundary;
    if (32'(remaining) < limit) limit = 32'(remaining);
    beats = 9'(limit);
    awlen = 8'(limit - 32'd1);
  end

endmodule

// File: rtl/dma_axi_wr_engine.sv
// DMA write drain: pops FIFO words and writes them as AXI4 INCR bursts,
// one burst outstanding at a time (AW, then W, then B).
module dma_axi_wr_engine
  import dma_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 32,
  parameter int LWIDTH     = 16,
  parameter int CWIDTH     = 33,
  parameter int FIFO_WORDS = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] dst_addr,
  input  logic [LWIDTH-1:0] len_words,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic [DWIDTH-1:0] fifo_data,
  input  logic              fifo_empty,
  input  logic [CWIDTH-1:0] fifo_depth_left,
  output logic              fifo_pull,
  dma_axi_wr_engine_if.master axi
);

  localparam int unsigned BYTE_SHIFT = $clog2(DWIDTH / 8);
  localparam logic [2:0]  AXI_SIZE   = axi_size_for(DWIDTH);

  wr_state_t         state, state_next;
  logic [AWIDTH-1:0] cur_addr;
  logic [LWIDTH-1:0] remaining;
  logic [LWIDTH-1:0] remaining_upd;
  logic [8:0]        beats_q;
  logic [7:0]        awlen_q;
  logic [7:0]        beat_cnt;
  logic              error_q;
  logic [8:0]        calc_beats;
  logic [7:0]        calc_awlen;
  logic              fifo_ready;
  logic              w_hs;
  logic              b_err;

  dma_burst_calc #(
    .LWIDTH    (LWIDTH),
    .DWIDTH    (DWIDTH),
    .MAX_BURST (MAX_BURST)
  ) u_burst_calc (
    .addr_offset (cur_addr[11:0]),
    .remaining   (remaining),
    .beats       (calc_beats),
    .awlen       (calc_awlen)
  );

  // The whole burst must already sit in the FIFO so W never waits on data.
  assign fifo_ready    = (CWIDTH'(FIFO_WORDS) - fifo_depth_left) >= CWIDTH'(calc_beats);
  assign w_hs          = axi.wvalid & axi.wready;
  assign b_err         = axi.bresp != AXI_RESP_OKAY;
  assign remaining_upd = remaining - LWIDTH'(beats_q);

  assign busy        = (state == CALC) || (state == AW) || (state == W) || (state == B);
  assign done        = state == DONE;
  assign error       = error_q;
  assign axi.awvalid = state == AW;
  assign axi.awaddr  = cur_addr;
  assign axi.awlen   = awlen_q;
  assign axi.awsize  = AXI_SIZE;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.wdata   = fifo_data;
  assign axi.wstrb   = '1;
  assign axi.wvalid  = (state == W) && !fifo_empty;
  assign axi.wlast   = (state == W) && (beat_cnt == awlen_q);
  assign axi.bready  = state == B;
  assign fifo_pull   = w_hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (len_words == '0) ? DONE : CALC;
      CALC: if (fifo_ready) state_next = AW;
      AW:   if (axi.awready) state_next = W;
      W:    if (w_hs && axi.wlast) state_next = B;
      B: begin
        if (axi.bvalid) begin
          if ((remaining_upd == '0) || b_err || error_q) state_next = DONE;
          else                                           state_next = CALC;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Burst geometry is frozen on leaving CALC; address/count advance only on B.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr  <= '0;
      remaining <= '0;
      beats_q   <= '0;
      awlen_q   <= '0;
      beat_cnt  <= '0;
      error_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cur_addr  <= dst_addr;
            remaining <= len_words;
            error_q   <= 1'b0;
          end
        end
        CALC: begin
          if (fifo_ready) begin
            beats_q  <= calc_beats;
            awlen_q  <= calc_awlen;
            beat_cnt <= '0;
          end
        end
        W: if (w_hs) beat_cnt <= beat_cnt + 8'd1;
        B: begin
          if (axi.bvalid) begin
            if (b_err) error_q <= 1'b1;
            cur_addr  <= cur_addr + (AWIDTH'(beats_q) << BYTE_SHIFT);
            remaining <= remaining_upd;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_axi_wr_engine.sv
// Directed self-checking bench for dma_axi_wr_engine with a FIFO model and AXI slave model.
module tb_dma_axi_wr_engine;

  localparam int DWIDTH     = 32;
  localparam int AWIDTH     = 32;
  localparam int LWIDTH     = 16;
  localparam int CWIDTH     = 33;
  localparam int FIFO_WORDS = 32;
  localparam int MAX_BURST  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [AWIDTH-1:0] dst_addr = '0;
  logic [LWIDTH-1:0] len_words = '0;
  logic              busy;
  logic              done;
  logic              error;
  logic [DWIDTH-1:0] fifo_data = '0;
  logic              fifo_empty = 1'b1;
  logic [CWIDTH-1:0] fifo_depth_left = CWIDTH'(FIFO_WORDS);
  logic              fifo_pull;

  dma_axi_wr_engine_if #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) axi ();

  dma_axi_wr_engine #(
    .DWIDTH     (DWIDTH),
    .AWIDTH     (AWIDTH),
    .LWIDTH     (LWIDTH),
    .CWIDTH     (CWIDTH),
    .FIFO_WORDS (FIFO_WORDS),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .dst_addr        (dst_addr),
    .len_words       (len_words),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .fifo_data       (fifo_data),
    .fifo_empty      (fifo_empty),
    .fifo_depth_left (fifo_depth_left),
    .fifo_pull       (fifo_pull),
    .axi             (axi.master)
  );

  always #5 clk = ~clk;

  int n_compared = 0;
  int n_mismatched = 0;

  // Controls written only by the stimulus process
  int          aw_pct = 100, w_pct = 100, b_pct = 100;
  int          refill_period = 1;
  int          err_burst = -1;
  int          load_seq = 0;
  int          load_count = 0;
  logic [31:0] load_base = '0;

  // FIFO / slave model state, written only by the posedge driver
  logic [31:0] fifo_q[$];
  int          load_seen = 0;
  int          src_left = 0;
  logic [31:0] next_word = '0;
  int          refill_cnt = 0;
  int          b_idx = 0;
  bit          b_wait = 0;

  // Monitor state, written only by the negedge monitor
  logic [31:0] aw_addr_log[$];
  int          aw_len_log[$];
  int          pulls = 0, done_cnt = 0;
  int          w_err = 0, stab_err = 0, empty_err = 0, occ_err = 0, cross_err = 0;
  int          beat_in_burst = 0, cur_len = 0;
  bit          hs_pull = 0, hs_wlast = 0, hs_b = 0;
  bit          aw_stall_prev = 0, w_stall_prev = 0, awvalid_prev = 0;
  logic [31:0] prev_awaddr = '0, prev_wdata = '0;
  logic [7:0]  prev_awlen = '0;
  logic        prev_wlast = 1'b0;

  task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Monitor: samples the cycle's settled values before the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      hs_pull = 0; hs_wlast = 0; hs_b = 0;
      aw_stall_prev = 0; w_stall_prev = 0; awvalid_prev = 0;
      beat_in_burst = 0;
    end else begin
      if (aw_stall_prev && (!axi.awvalid || axi.awaddr !== prev_awaddr || axi.awlen !== prev_awlen))
        stab_err++;
      if (axi.awvalid && !awvalid_prev && (fifo_q.size() < int'(axi.awlen) + 1))
        occ_err++;
      if (axi.awvalid && (int'(axi.awaddr[11:0]) + (int'(axi.awlen) + 1) * 4 > 4096))
        cross_err++;
      if (axi.awvalid && (axi.wvalid || axi.bready))
        stab_err++;
      if (axi.awvalid && axi.awready) begin
        aw_addr_log.push_back(axi.awaddr);
        aw_len_log.push_back(int'(axi.awlen));
        cur_len = int'(axi.awlen);
        beat_in_burst = 0;
      end
      aw_stall_prev = axi.awvalid && !axi.awready;
      prev_awaddr   = axi.awaddr;
      prev_awlen    = axi.awlen;
      awvalid_prev  = axi.awvalid;

      if (w_stall_prev && (!axi.wvalid || axi.wdata !== prev_wdata || axi.wlast !== prev_wlast))
        stab_err++;
      if (axi.wvalid && fifo_empty) empty_err++;
      if (fifo_pull !== (axi.wvalid && axi.wready)) w_err++;
      if (axi.wvalid && axi.wready) begin
        pulls++;
        if (fifo_q.size() == 0 || axi.wdata !== fifo_q[0]) w_err++;
        if (axi.wlast !== (beat_in_burst == cur_len)) w_err++;
        beat_in_burst++;
      end
      w_stall_prev = axi.wvalid && !axi.wready;
      prev_wdata   = axi.wdata;
      prev_wlast   = axi.wlast;

      if (done) done_cnt++;
      hs_pull  = fifo_pull;
      hs_wlast = axi.wvalid && axi.wready && axi.wlast;
      hs_b     = axi.bvalid && axi.bready;
    end
  end

  // Driver: FIFO model and AXI slave responses change #1 after the rising edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      axi.bvalid = 1'b0;
      axi.bresp  = 2'b00;
      b_wait     = 0;
    end else begin
      if (hs_pull && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (hs_b) begin
        axi.bvalid = 1'b0;
        b_idx++;
      end
      if (hs_wlast) b_wait = 1;
      if (b_wait && !axi.bvalid && ($urandom_range(99) < b_pct)) begin
        axi.bvalid = 1'b1;
        axi.bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
        b_wait     = 0;
      end
    end
    if (load_seen != load_seq) begin
      load_seen  = load_seq;
      fifo_q.delete();
      src_left   = load_count;
      next_word  = load_base;
      refill_cnt = 0;
      b_idx      = 0;
    end
    if (src_left > 0 && fifo_q.size() < FIFO_WORDS) begin
      refill_cnt++;
      if (refill_cnt >= refill_period) begin
        fifo_q.push_back(next_word);
        next_word  = next_word + 32'h0101_0103;
        src_left--;
        refill_cnt = 0;
      end
    end
    fifo_empty      = (fifo_q.size() == 0);
    fifo_data       = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    fifo_depth_left = CWIDTH'(FIFO_WORDS - fifo_q.size());
    axi.awready     = ($urandom_range(99) < aw_pct);
    axi.wready      = ($urandom_range(99) < w_pct);
  end

  task automatic load_source(input int count, input logic [31:0] base, input int period);
    load_count    = count;
    load_base     = base;
    refill_period = period;
    load_seq++;
  endtask

  task automatic apply_stimulus(input logic [31:0] addr, input int len);
    @(posedge clk); #1;
    dst_addr  = addr;
    len_words = LWIDTH'(len);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    bit seen = 0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    if (!seen) check_output({tag, "_done_timeout"}, 0, 1);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_done"}, done, 0);
    check_output({tag, "_error"}, error, 0);
    check_output({tag, "_fifo_pull"}, fifo_pull, 0);
    check_output({tag, "_awvalid"}, axi.awvalid, 0);
    check_output({tag, "_wvalid"}, axi.wvalid, 0);
    check_output({tag, "_bready"}, axi.bready, 0);
    check_output({tag, "_awaddr"}, axi.awaddr, 0);
    check_output({tag, "_awlen"}, axi.awlen, 0);
    check_output({tag, "_wlast"}, axi.wlast, 0);
  endtask

  int base_bursts, base_pulls, base_done;

  task automatic mark_bases();
    base_bursts = aw_addr_log.size();
    base_pulls  = pulls;
    base_done   = done_cnt;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit hit;
    $display("[TB] starting dma_axi_wr_engine bench");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    check_output("rst_awsize", axi.awsize, 3'd2);
    check_output("rst_awburst", axi.awburst, 2'b01);
    check_output("rst_wstrb", axi.wstrb, 4'hF);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single 4-beat burst, FIFO pre-filled, always-ready slave
    load_source(4, 32'hA000_0000, 1);
    repeat (8) @(posedge clk);
    mark_bases();
    apply_stimulus(32'h0000_1000, 4);
    @(negedge clk);
    check_output("t1_busy", busy, 1);
    wait_done("t1", 200);
    check_output("t1_done_pulse_len", done, 0);
    check_output("t1_bursts", aw_addr_log.size() - base_bursts, 1);
    check_output("t1_awaddr", aw_addr_log[base_bursts], 32'h0000_1000);
    check_output("t1_awlen", aw_len_log[base_bursts], 3);
    check_output("t1_pulls", pulls - base_pulls, 4);
    check_output("t1_done_cnt", done_cnt - base_done, 1);
    check_output("t1_error", error, 0);
    check_output("t1_busy_after", busy, 0);

    // 4 KB split: 2 words before the boundary, 6 after
    load_source(8, 32'hB000_0000, 1);
    repeat (12) @(posedge clk);
    mark_bases();
    apply_stimulus(32'h0000_0FF8, 8);
    wait_done("t2", 300);
    check_output("t2_bursts", aw_addr_log.size() - base_bursts, 2);
    check_output("t2_awaddr0", aw_addr_log[base_bursts], 32'h0000_0FF8);
    check_output("t2_awlen0", aw_len_log[base_bursts], 1);
    check_output("t2_awaddr1", aw_addr_log[base_bursts + 1], 32'h0000_1000);
    check_output("t2_awlen1", aw_len_log[base_bursts + 1], 5);
    check_output("t2_pulls", pulls - base_pulls, 8);

    // Slow refill: each AW must wait for the whole burst to be present
    mark_bases();
    load_source(40, 32'hC000_0000, 3);
    apply_stimulus(32'h0000_2000, 40);
    wait_done("t3", 1500);
    check_output("t3_bursts", aw_addr_log.size() - base_bursts, 3);
    check_output("t3_awlen0", aw_len_log[base_bursts], 15);
    check_output("t3_awlen1", aw_len_log[base_bursts + 1], 15);
    check_output("t3_awlen2", aw_len_log[base_bursts + 2], 7);
    check_output("t3_awaddr2", aw_addr_log[base_bursts + 2], 32'h0000_2080);
    check_output("t3_occupancy", occ_err, 0);
    check_output("t3_empty_beats", empty_err, 0);
    check_output("t3_pulls", pulls - base_pulls, 40);

    // Random backpressure on all three channels, crossing a 4 KB line
    aw_pct = 50; w_pct = 50; b_pct = 40;
    mark_bases();
    load_source(40, 32'hD000_0000, 1);
    apply_stimulus(32'h0000_3FC0, 40);
    wait_done("t4", 3000);
    check_output("t4_bursts", aw_addr_log.size() - base_bursts, 3);
    check_output("t4_awaddr1", aw_addr_log[base_bursts + 1], 32'h0000_4000);
    check_output("t4_awlen2", aw_len_log[base_bursts + 2], 7);
    check_output("t4_pulls", pulls - base_pulls, 40);
    check_output("t4_stable", stab_err, 0);
    check_output("t4_wdata_wlast", w_err, 0);
    check_output("t4_4k_cross", cross_err, 0);
    aw_pct = 100; w_pct = 100; b_pct = 100;

    // SLVERR on the first of three bursts stops the transfer
    err_burst = 0;
    mark_bases();
    load_source(48, 32'hE000_0000, 1);
    repeat (20) @(posedge clk);
    apply_stimulus(32'h0000_5000, 48);
    wait_done("t5", 500);
    check_output("t5_bursts", aw_addr_log.size() - base_bursts, 1);
    check_output("t5_pulls", pulls - base_pulls, 16);
    check_output("t5_done_cnt", done_cnt - base_done, 1);
    check_output("t5_error", error, 1);
    repeat (5) @(negedge clk);
    check_output("t5_error_sticky", error, 1);
    check_output("t5_no_more_aw", aw_addr_log.size() - base_bursts, 1);
    err_burst = -1;

    // Zero-length start: done follows directly and clears the old error
    load_source(0, 32'h0, 1);
    repeat (2) @(posedge clk);
    mark_bases();
    @(posedge clk); #1;
    dst_addr = 32'h0000_9000; len_words = '0; start = 1'b1;
    @(negedge clk);
    check_output("t6_done_early", done, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_output("t6_done", done, 1);
    check_output("t6_error_cleared", error, 0);
    check_output("t6_busy", busy, 0);
    @(negedge clk);
    check_output("t6_done_one_cycle", done, 0);
    check_output("t6_no_aw", aw_addr_log.size() - base_bursts, 0);

    // Asynchronous reset in the middle of a W burst
    w_pct = 60;
    load_source(16, 32'hF000_0000, 1);
    repeat (20) @(posedge clk);
    mark_bases();
    apply_stimulus(32'h0000_6000, 16);
    hit = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if ((pulls - base_pulls) >= 3 && axi.wvalid) begin hit = 1; break; end
    end
    if (!hit) check_output("t7_reach_w_timeout", 0, 1);
    #2 rst = 1'b1;
    #1;
    check_output("t7_async_wvalid", axi.wvalid, 0);
    check_output("t7_async_busy", busy, 0);
    @(negedge clk);
    check_reset_values("t7");
    @(posedge clk); #1;
    rst = 1'b0;
    w_pct = 100;

    // Recovery after reset
    load_source(2, 32'h1234_0000, 1);
    repeat (6) @(posedge clk);
    mark_bases();
    apply_stimulus(32'h0000_7000, 2);
    wait_done("t8", 200);
    check_output("t8_bursts", aw_addr_log.size() - base_bursts, 1);
    check_output("t8_awaddr", aw_addr_log[base_bursts], 32'h0000_7000);
    check_output("t8_awlen", aw_len_log[base_bursts], 1);
    check_output("t8_pulls", pulls - base_pulls, 2);
    check_output("final_wdata_wlast", w_err, 0);
    check_output("final_stable", stab_err, 0);
    check_output("final_empty_beats", empty_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
